status_flag_unit: RTL and testbench
===================================

Name: status_flag_unit

Overview:
- Producer of the |N|Z|C|V| status bits that the condition-check logic consumes.
- Takes ALU results, plus direct flag writes of the MSR kind, through a one-entry pending stage.
- Commits them to the architectural status register.
- Exposes committed flags, forwarded flags and a pending indication to the issue/condition logic.

Parameters:
WIDTH, 32, ALU result width in bits
CNT_W, 8, width of committed-update counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
alu_valid  input  1  an instruction result is presented this cycle
alu_s  input  1  S bit; flags update only when 1
alu_kind  input  2  00 logical, 01 arithmetic, 10 flag write, 11 reserved
alu_result  input  WIDTH  ALU result
alu_carry  input  1  adder carry-out
alu_ovf  input  1  adder signed overflow
shifter_carry  input  1  barrel-shifter carry-out
msr_flags  input  4  direct flag value {N,Z,C,V}
stall  input  1  freeze the unit
flush  input  1  discard the pending update and this cycle's input
status_bits  output  4  committed flags {N,Z,C,V}; bit3 = N, bit0 = V
status_fwd  output  4  flags the next instruction must observe
pending  output  1  pending stage holds an uncommitted update
upd_count  output  CNT_W  number of committed updates

Behaviour:
- Reset (synchronous, rst = 1 at a rising edge):
  - status_bits = 4'b0000; pending stage cleared (pending = 0); upd_count = 0; status_fwd = 4'b0000.
  - rst has priority over every other input.
- Accept condition: accept = alu_valid & alu_s & (alu_kind != 2'b11) & ~stall & ~flush.
  - alu_kind 11, or alu_s = 0, is ignored and leaves no pending entry.
- Base flags: base = pending ? P_flags : status_bits. This gives back-to-back correctness.
- New flag computation, combinational on the accept cycle:
  - logical: N = alu_result[WIDTH-1]; Z = (alu_result == 0); C = shifter_carry; V = base.V.
  - arithmetic: N and Z as for logical; C = alu_carry; V = alu_ovf.
  - flag write: {N,Z,C,V} = msr_flags.
- Pipeline:
  - Stage P is one entry: valid bit plus 4 flags.
  - Edge n, accept = 1: P loads the new flags and P_valid = 1.
  - Edge n+1: if P_valid and no stall, status_bits <= P_flags and upd_count increments.
  - Input-to-commit latency is 2 edges.
- Simultaneous commit and accept: the P entry commits while the new result loads into P. This sustains one update per cycle with no bubble.
- P_valid clears at commit unless a new accept occurs on the same edge.
- stall = 1 (flush = 0): P, status_bits and upd_count all hold. Inputs are ignored.
- flush = 1: P_valid <= 0 and the pending flags are dropped, never committed. status_bits and upd_count are unchanged and the input is ignored. flush overrides stall.
- pending = P_valid, registered.
- upd_count saturates at all-ones; it never wraps.
- status_fwd: see Optional Feature.

Optional Feature:
- Macro: STATUS_FWD_EN.
- Defined: status_fwd = P_valid ? P_flags : status_bits, combinational from registers. A dependent instruction reads correct flags with no stall.
- Undefined: status_fwd = status_bits. Issue logic must stall while pending = 1. The base-flag selection for V preservation remains internal in both builds.

Test Plan:
- Reset then arithmetic: alu_valid = 1, alu_s = 1, kind = 01, result = 0, carry = 1, ovf = 0.
  - After edge 1: pending = 1; status_fwd = 0110 (with STATUS_FWD_EN).
  - After edge 2: status_bits = 0110, upd_count = 1, pending = 0.
- Logical preserves V: msr_flags = 0001 written first, then logical with result = 0x8000_0000 and shifter_carry = 0 on the next cycle.
  - Final status_bits = 1001 (N = 1, Z = 0, C = 0, V kept from the pending entry).
- Back-to-back throughput: 4 consecutive accepted arithmetic ops.
  - status_bits changes on 4 consecutive edges starting at edge 2; final upd_count = 4; pending stays 1 until after the last commit.
- Flush mid-operation: accept a flag write of 1111, then flush = 1 on the next cycle while status_bits = 0000.
  - pending = 0; status_bits stays 0000; upd_count is unchanged.
- Stall then flush: accept, stall for 3 cycles, then flush and stall both high.
  - status_bits is unchanged throughout and pending = 0 after the flush edge.
  - Input with alu_s = 0 or kind = 11 never sets pending.
- Counter saturation with CNT_W = 2: 5 commits give upd_count = 3.

Source files
------------

// File: rtl/status_flag_unit_if.sv
// Bundle of ALU/flag-write inputs and status outputs for status_flag_unit.
// The master drives ALU results and control; the slave returns committed/forwarded flags.
interface status_flag_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
);
  logic             alu_valid;
  logic             alu_s;
  logic [1:0]       alu_kind;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_ovf;
  logic             shifter_carry;
  logic [3:0]       msr_flags;
  logic             stall;
  logic             flush;
  logic [3:0]       status_bits;
  logic [3:0]       status_fwd;
  logic             pending;
  logic [CNT_W-1:0] upd_count;

  modport master (
    output alu_valid, alu_s, alu_kind, alu_result, alu_carry, alu_ovf,
           shifter_carry, msr_flags, stall, flush,
    input  status_bits, status_fwd, pending, upd_count
  );

  modport slave (
    input  alu_valid, alu_s, alu_kind, alu_result, alu_carry, alu_ovf,
           shifter_carry, msr_flags, stall, flush,
    output status_bits, status_fwd, pending, upd_count
  );
endinterface

// File: rtl/status_flag_unit.sv
// NZCV status producer: one-entry pending stage feeding the architectural status register.
// Optional macro STATUS_FWD_EN forwards the pending flags on status_fwd.
module status_flag_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  status_flag_unit_if.slave bus
);

  typedef enum logic [1:0] {
    KIND_LOGIC = 2'b00,
    KIND_ARITH = 2'b01,
    KIND_MSR   = 2'b10,
    KIND_RSVD  = 2'b11
  } kind_e;

  logic [3:0]       status_q;
  logic [3:0]       p_flags;
  logic             p_valid;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic [3:0]       base;
  logic [3:0]       new_flags;
  logic             res_n;
  logic             res_z;

  always_comb begin
    accept    = bus.alu_valid & bus.alu_s & (kind_e'(bus.alu_kind) != KIND_RSVD)
              & ~bus.stall & ~bus.flush;
    // Base comes from the pending entry so back-to-back ops see the newest V.
    base      = p_valid ? p_flags : status_q;
    res_n     = bus.alu_result[WIDTH-1];
    res_z     = (bus.alu_result == '0);
    new_flags = base;
    case (kind_e'(bus.alu_kind))
      KIND_LOGIC: new_flags = {res_n, res_z, bus.shifter_carry, base[0]};
      KIND_ARITH: new_flags = {res_n, res_z, bus.alu_carry, bus.alu_ovf};
      KIND_MSR:   new_flags = bus.msr_flags;
      default:    new_flags = base;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
      p_flags  <= '0;
      p_valid  <= 1'b0;
      cnt_q    <= '0;
    end else if (bus.flush) begin
      p_valid <= 1'b0;
    end else if (!bus.stall) begin
      if (p_valid) begin
        status_q <= p_flags;
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end
      p_valid <= accept;
      if (accept) p_flags <= new_flags;
    end
  end

  assign bus.status_bits = status_q;
  assign bus.pending     = p_valid;
  assign bus.upd_count   = cnt_q;

`ifdef STATUS_FWD_EN
  assign bus.status_fwd = p_valid ? p_flags : status_q;
`else
  assign bus.status_fwd = status_q;
`endif

endmodule

// File: tb/tb_status_flag_unit.sv
// Scoreboard bench for status_flag_unit: a default instance plus a CNT_W=2 instance
// driven with identical stimulus; per-cycle expectations are queued and popped after each edge.
module tb_status_flag_unit;

  logic        clk;
  logic        rst;
  logic        alu_valid, alu_s, alu_carry, alu_ovf, shifter_carry, stall, flush;
  logic [1:0]  alu_kind;
  logic [31:0] alu_result;
  logic [3:0]  msr_flags;

  int unsigned total;
  int unsigned bad;

  status_flag_unit_if #(.WIDTH(32), .CNT_W(8)) bus ();
  status_flag_unit_if #(.WIDTH(32), .CNT_W(2)) bus2 ();

  assign bus.alu_valid      = alu_valid;
  assign bus.alu_s          = alu_s;
  assign bus.alu_kind       = alu_kind;
  assign bus.alu_result     = alu_result;
  assign bus.alu_carry      = alu_carry;
  assign bus.alu_ovf        = alu_ovf;
  assign bus.shifter_carry  = shifter_carry;
  assign bus.msr_flags      = msr_flags;
  assign bus.stall          = stall;
  assign bus.flush          = flush;
  assign bus2.alu_valid     = alu_valid;
  assign bus2.alu_s         = alu_s;
  assign bus2.alu_kind      = alu_kind;
  assign bus2.alu_result    = alu_result;
  assign bus2.alu_carry     = alu_carry;
  assign bus2.alu_ovf       = alu_ovf;
  assign bus2.shifter_carry = shifter_carry;
  assign bus2.msr_flags     = msr_flags;
  assign bus2.stall         = stall;
  assign bus2.flush         = flush;

  status_flag_unit #(.WIDTH(32), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  status_flag_unit #(.WIDTH(32), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] bits;
    logic [3:0] fwd;
    logic       pend;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;

  exp_t sb[$];

  // Reference state
  logic [3:0] m_flags;
  logic [3:0] m_pf;
  logic       m_pv;
  int unsigned m_cnt;
  int unsigned m_cnt2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] flags_of(input logic [1:0] kind, input logic [31:0] res,
                                          input logic c, input logic v, input logic sc,
                                          input logic [3:0] msr, input logic [3:0] b);
    logic n, z;
    n = res[31];
    z = (res == 32'd0);
    if (kind == 2'b00) return {n, z, sc, b[0]};
    if (kind == 2'b01) return {n, z, c, v};
    return msr;
  endfunction

  task automatic model_edge();
    logic acc;
    logic [3:0] b, nf;
    if (rst) begin
      m_flags = 4'h0; m_pf = 4'h0; m_pv = 1'b0; m_cnt = 0; m_cnt2 = 0;
    end else if (flush) begin
      m_pv = 1'b0;
    end else if (!stall) begin
      acc = alu_valid && alu_s && alu_kind != 2'b11;
      b   = m_pv ? m_pf : m_flags;
      nf  = flags_of(alu_kind, alu_result, alu_carry, alu_ovf, shifter_carry, msr_flags, b);
      if (m_pv) begin
        m_flags = m_pf;
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      m_pv = acc;
      if (acc) m_pf = nf;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic s, input logic [1:0] k,
                      input logic [31:0] res, input logic c, input logic o, input logic sc,
                      input logic [3:0] msr, input logic st, input logic fl);
    exp_t e, g;
    rst = r; alu_valid = v; alu_s = s; alu_kind = k; alu_result = res;
    alu_carry = c; alu_ovf = o; shifter_carry = sc; msr_flags = msr; stall = st; flush = fl;
    model_edge();
    e.bits = m_flags;
`ifdef STATUS_FWD_EN
    e.fwd  = m_pv ? m_pf : m_flags;
`else
    e.fwd  = m_flags;
`endif
    e.pend = m_pv;
    e.cnt  = 8'(m_cnt);
    e.cnt2 = 2'(m_cnt2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      g = sb.pop_front();
      check("status_bits", 32'(bus.status_bits), 32'(g.bits));
      check("status_fwd",  32'(bus.status_fwd),  32'(g.fwd));
      check("pending",     32'(bus.pending),     32'(g.pend));
      check("upd_count",   32'(bus.upd_count),   32'(g.cnt));
      check("upd_count_w2", 32'(bus2.upd_count), 32'(g.cnt2));
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask
  task automatic idle(input logic st = 1'b0, input logic fl = 1'b0);
    step(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 4'h0, st, fl);
  endtask
  task automatic arith(input logic [31:0] res, input logic c, input logic o,
                       input logic st = 1'b0, input logic fl = 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'b01, res, c, o, 1'b0, 4'h0, st, fl);
  endtask
  task automatic logic_op(input logic [31:0] res, input logic sc);
    step(1'b0, 1'b1, 1'b1, 2'b00, res, 1'b0, 1'b0, sc, 4'h0, 1'b0, 1'b0);
  endtask
  task automatic msr_wr(input logic [3:0] f, input logic fl = 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'b10, 32'd0, 1'b0, 1'b0, 1'b0, f, 1'b0, fl);
  endtask

  initial begin
    total = 0; bad = 0;
    m_flags = 4'h0; m_pf = 4'h0; m_pv = 1'b0; m_cnt = 0; m_cnt2 = 0;
    rst = 1'b1; alu_valid = 1'b0; alu_s = 1'b0; alu_kind = 2'b00; alu_result = 32'd0;
    alu_carry = 1'b0; alu_ovf = 1'b0; shifter_carry = 1'b0; msr_flags = 4'h0;
    stall = 1'b0; flush = 1'b0;

    // Reset then arithmetic with zero result
    do_reset();
    check("rst_bits", 32'(bus.status_bits), 32'h0);
    check("rst_cnt", 32'(bus.upd_count), 32'h0);
    arith(32'd0, 1'b1, 1'b0);
    check("t1_pend", 32'(bus.pending), 32'h1);
`ifdef STATUS_FWD_EN
    check("t1_fwd", 32'(bus.status_fwd), 32'h6);
`endif
    idle();
    check("t1_bits", 32'(bus.status_bits), 32'h6);
    check("t1_cnt", 32'(bus.upd_count), 32'h1);

    // Logical keeps V from the pending flag write
    msr_wr(4'b0001);
    logic_op(32'h8000_0000, 1'b0);
    idle();
    check("t2_bits", 32'(bus.status_bits), 32'h9);

    // Four back-to-back arithmetic ops
    do_reset();
    arith(32'h0000_0001, 1'b0, 1'b1);
    arith(32'h8000_0000, 1'b1, 1'b0);
    arith(32'h0000_0000, 1'b0, 1'b0);
    check("t3_pend_mid", 32'(bus.pending), 32'h1);
    arith(32'hFFFF_FFFF, 1'b1, 1'b1);
    idle();
    check("t3_bits", 32'(bus.status_bits), 32'hB);
    check("t3_cnt", 32'(bus.upd_count), 32'h4);
    check("t3_pend_end", 32'(bus.pending), 32'h0);
    idle();

    // Flush drops a pending flag write
    do_reset();
    msr_wr(4'b1111);
    msr_wr(4'b1010, 1'b1);
    check("t4_pend", 32'(bus.pending), 32'h0);
    check("t4_bits", 32'(bus.status_bits), 32'h0);
    idle();
    check("t4_cnt", 32'(bus.upd_count), 32'h0);

    // Stall three cycles then flush+stall
    arith(32'h8000_0000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) arith(32'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_bits_stall", 32'(bus.status_bits), 32'h0);
    idle(1'b1, 1'b1);
    check("t5_pend", 32'(bus.pending), 32'h0);
    check("t5_bits", 32'(bus.status_bits), 32'h0);

    // Ignored inputs
    step(1'b0, 1'b1, 1'b0, 2'b01, 32'd0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
    check("t6_s0", 32'(bus.pending), 32'h0);
    step(1'b0, 1'b1, 1'b1, 2'b11, 32'd0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
    check("t6_k3", 32'(bus.pending), 32'h0);

    // Saturation of the 2-bit counter
    do_reset();
    for (int i = 0; i < 5; i++) arith(32'(i), 1'(i), 1'b0);
    idle();
    check("t7_cnt2", 32'(bus2.upd_count), 32'h3);
    check("t7_cnt", 32'(bus.upd_count), 32'h5);

    // Random mix
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
           2'($urandom_range(0, 3)), r, 1'($urandom), 1'($urandom), 1'($urandom),
           4'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
